// File: rtl/spi_reg_bridge.sv
// Byte-level bridge from an SPI slave to a simple register bus.
// Frame: {RW, ADDR[6:0]} followed by data bytes; reads are fetched one byte ahead of MISO.
module spi_reg_bridge #(
    parameter logic [7:0]  DUMMY_BYTE = 8'h00,
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          AUTO_INC   = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Recive_Data,
    input  logic       Recive_Data_Valid,
    input  logic       Trans_Start,
    input  logic       Trans_End,
    output logic [7:0] Send_Data,
    output logic       Send_Data_Valid,
    output logic [6:0] Reg_Addr,
    output logic [7:0] Reg_Wdata,
    output logic       Reg_Wr,
    output logic       Reg_Rd,
    input  logic [7:0] Reg_Rdata,
    output logic       Busy,
    output logic       Rd_Underrun
);

    // Out-of-range latencies are clamped so the fetch counter always terminates.
    localparam int unsigned LAT     = (RD_LATENCY < 1) ? 1 : ((RD_LATENCY > 4) ? 4 : RD_LATENCY);
    localparam logic [2:0]  LAT_CNT = 3'(LAT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WR_DATA  = 3'd2,
        RD_FETCH = 3'd3,
        RD_DATA  = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_send_data;
    logic       r_send_valid;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_wr;
    logic       r_rd;
    logic       r_underrun;
    logic [2:0] r_cnt;

    state_t     w_state_next;
    logic [7:0] w_send_data_next;
    logic       w_send_valid_next;
    logic [6:0] w_addr_next;
    logic [7:0] w_wdata_next;
    logic       w_wr_next;
    logic       w_rd_next;
    logic       w_underrun_next;
    logic [2:0] w_cnt_next;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_send_data  <= DUMMY_BYTE;
            r_send_valid <= 1'b0;
            r_addr       <= 7'd0;
            r_wdata      <= 8'd0;
            r_wr         <= 1'b0;
            r_rd         <= 1'b0;
            r_underrun   <= 1'b0;
            r_cnt        <= 3'd0;
        end else begin
            r_state      <= w_state_next;
            r_send_data  <= w_send_data_next;
            r_send_valid <= w_send_valid_next;
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
            r_wr         <= w_wr_next;
            r_rd         <= w_rd_next;
            r_underrun   <= w_underrun_next;
            r_cnt        <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_send_data_next  = r_send_data;
        w_send_valid_next = 1'b0;
        w_wdata_next      = r_wdata;
        w_wr_next         = 1'b0;
        w_rd_next         = 1'b0;
        w_underrun_next   = r_underrun;
        w_cnt_next        = (r_cnt != 3'd0) ? (r_cnt - 3'd1) : 3'd0;
        // A write's address step lands the cycle after its strobe, so Reg_Addr is stable under Reg_Wr.
        if (AUTO_INC && r_wr) begin
            w_addr_next = r_addr + 7'd1;
        end else begin
            w_addr_next = r_addr;
        end

        unique case (r_state)
            IDLE: begin
            end
            CMD: begin
                if (Recive_Data_Valid) begin
                    w_addr_next = Recive_Data[6:0];
                    if (!Recive_Data[7]) begin
                        w_state_next = WR_DATA;
                    end else if (!Trans_End) begin
                        w_rd_next    = 1'b1;
                        w_cnt_next   = LAT_CNT;
                        w_state_next = RD_FETCH;
                    end
                end
            end
            WR_DATA: begin
                if (Recive_Data_Valid) begin
                    w_wr_next    = 1'b1;
                    w_wdata_next = Recive_Data;
                end
            end
            RD_FETCH: begin
                if (Recive_Data_Valid) begin
                    w_underrun_next = 1'b1;
                end
                // A fetch cut short by CS rising still finishes on the bus but never reaches MISO.
                if ((r_cnt == 3'd0) && !Trans_End) begin
                    w_send_data_next  = Reg_Rdata;
                    w_send_valid_next = 1'b1;
                    w_state_next      = RD_DATA;
                end
            end
            RD_DATA: begin
                if (Recive_Data_Valid) begin
                    if (AUTO_INC) begin
                        w_addr_next = r_addr + 7'd1;
                    end
                    if (!Trans_End) begin
                        w_rd_next    = 1'b1;
                        w_cnt_next   = LAT_CNT;
                        w_state_next = RD_FETCH;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (Trans_End) begin
            w_state_next = IDLE;
        end
        if (Trans_Start) begin
            w_state_next      = CMD;
            w_send_data_next  = DUMMY_BYTE;
            w_send_valid_next = 1'b1;
            w_wr_next         = 1'b0;
            w_rd_next         = 1'b0;
        end
    end

    assign Send_Data       = r_send_data;
    assign Send_Data_Valid = r_send_valid;
    assign Reg_Addr        = r_addr;
    assign Reg_Wdata       = r_wdata;
    assign Reg_Wr          = r_wr;
    assign Reg_Rd          = r_rd;
    assign Busy            = (r_state != IDLE);
    assign Rd_Underrun     = r_underrun;

endmodule
